// File: rtl/pc_ctrl.sv
// Fetch-stage program counter with branch/jump redirect and a circular
// return-address stack that restores the PC on call/return pairs.
module pc_ctrl #(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VEC = '0,
   parameter int unsigned      STEP      = 4,
   parameter int unsigned      RAS_DEPTH = 4,
   localparam int unsigned     CW        = $clog2(RAS_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_target,
   input  logic             call,
   input  logic             ret,
   output logic [WIDTH-1:0] pc_out,
   output logic [CW-1:0]    ras_count,
   output logic             ras_overflow,
   output logic             ras_underflow
);

   localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam logic [PW-1:0] PTR_LAST = PW'(RAS_DEPTH - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(RAS_DEPTH);

   logic [WIDTH-1:0] pc_q, pc_d, pc_seq;
   logic [WIDTH-1:0] ras_q [RAS_DEPTH];
   logic [PW-1:0]    ptr_q, ptr_d, ptr_inc, ptr_dec;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ovf_q, ovf_d, unf_q, unf_d;
   logic             push;

   assign pc_seq = pc_q + WIDTH'(STEP);

   // ptr_q addresses the next free slot; the top entry sits one below it.
   assign ptr_inc = (ptr_q == PTR_LAST) ? '0 : ptr_q + PW'(1);
   assign ptr_dec = (ptr_q == '0) ? PTR_LAST : ptr_q - PW'(1);

   always_comb begin
      pc_d  = pc_q;
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      unf_d = unf_q;
      push  = 1'b0;
      if (!stall) begin
         if (redirect_valid) begin
            pc_d = redirect_target;
            push = call;
         end else if (ret) begin
            if (cnt_q != '0) begin
               pc_d  = ras_q[ptr_dec];
               ptr_d = ptr_dec;
               cnt_d = cnt_q - CW'(1);
            end else begin
               pc_d  = pc_seq;
               unf_d = 1'b1;
            end
         end else begin
            pc_d = pc_seq;
         end
      end
      // A push on a full stack lands on the oldest slot, which is where ptr_q points.
      if (push) begin
         ptr_d = ptr_inc;
         if (cnt_q == CNT_FULL) begin
            ovf_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q  <= RESET_VEC;
         ptr_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   // Stack storage is never cleared; reset only invalidates it via the count.
   always_ff @(posedge clk) begin
      if (rst && push) begin
         ras_q[ptr_q] <= pc_seq;
      end
   end

   assign pc_out        = pc_q;
   assign ras_count     = cnt_q;
   assign ras_overflow  = ovf_q;
   assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Bench for pc_ctrl: directed scenarios plus random traffic, all checked
// against a queue-based model of the PC and return-address stack.
module tb_pc_ctrl;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = '0;
   logic        call = 1'b0;
   logic        ret = 1'b0;
   logic [31:0] pc_out;
   logic [2:0]  ras_count;
   logic        ras_overflow;
   logic        ras_underflow;

   int total = 0;
   int bad = 0;

   // Reference model state
   logic [31:0] m_pc = '0;
   logic [31:0] m_stk[$];
   logic        m_ovf = 1'b0;
   logic        m_unf = 1'b0;

   pc_ctrl #(
      .WIDTH     (32),
      .RESET_VEC (32'h0),
      .STEP      (4),
      .RAS_DEPTH (DEPTH)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .call            (call),
      .ret             (ret),
      .pc_out          (pc_out),
      .ras_count       (ras_count),
      .ras_overflow    (ras_overflow),
      .ras_underflow   (ras_underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      if (!rst) begin
         m_pc = 32'h0;
         m_stk.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else if (stall) begin
         // hold everything
      end else if (redirect_valid) begin
         if (call) begin
            if (m_stk.size() == DEPTH) begin
               void'(m_stk.pop_front());
               m_ovf = 1'b1;
            end
            m_stk.push_back(m_pc + 32'd4);
         end
         m_pc = redirect_target;
      end else if (ret) begin
         if (m_stk.size() > 0) begin
            m_pc = m_stk.pop_back();
         end else begin
            m_pc = m_pc + 32'd4;
            m_unf = 1'b1;
         end
      end else begin
         m_pc = m_pc + 32'd4;
      end
   endtask

   // Apply one cycle of inputs, advance model and DUT, compare after the edge.
   task automatic step(input string tag, input logic r, input logic st, input logic rv,
                       input logic [31:0] tgt, input logic cl, input logic rt);
      rst = r;
      stall = st;
      redirect_valid = rv;
      redirect_target = tgt;
      call = cl;
      ret = rt;
      model_edge();
      @(posedge clk);
      #1;
      chk({tag, "_pc"}, pc_out, m_pc);
      chk({tag, "_cnt"}, 32'(ras_count), 32'(m_stk.size()));
      chk({tag, "_ovf"}, 32'(ras_overflow), 32'(m_ovf));
      chk({tag, "_unf"}, 32'(ras_underflow), 32'(m_unf));
   endtask

   task automatic seq(input string tag);
      step(tag, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   initial begin
      // 1: reset then free-running
      step("rst", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("rst_pc_lit", pc_out, 32'h0);
      seq("t1a");
      seq("t1b");
      seq("t1c");
      chk("t1_pc_lit", pc_out, 32'hC);

      // 2: stall holds PC and masks a pending redirect
      step("t2s0", 1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 1'b0);
      step("t2s1", 1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 1'b0);
      chk("t2_hold_lit", pc_out, 32'hC);
      step("t2go", 1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0);
      chk("t2_land_lit", pc_out, 32'h100);

      // 3: call/return pair
      step("t3to", 1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 1'b0);
      step("t3call", 1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 1'b0);
      chk("t3_cnt_lit", 32'(ras_count), 32'd1);
      seq("t3s1");
      seq("t3s2");
      chk("t3_seq_lit", pc_out, 32'h208);
      step("t3ret", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      chk("t3_ret_lit", pc_out, 32'h14);

      // 4: overflow then underflow
      step("t4rst", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         step("t4call", 1'b1, 1'b0, 1'b1, 32'(i) << 8, 1'b1, 1'b0);
      end
      chk("t4_cnt_lit", 32'(ras_count), 32'd4);
      chk("t4_ovf_lit", 32'(ras_overflow), 32'd1);
      for (int i = 4; i >= 1; i--) begin
         step("t4ret", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
         chk("t4_ret_lit", pc_out, (32'(i) << 8) + 32'd4);
      end
      step("t4unf", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      chk("t4_unf_pc_lit", pc_out, 32'h108);
      chk("t4_unf_lit", 32'(ras_underflow), 32'd1);

      // 5: wrap, then redirect beats ret on the same edge
      step("t5call", 1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 1'b0);
      step("t5to", 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
      seq("t5wrap");
      chk("t5_wrap_lit", pc_out, 32'h0);
      step("t5both", 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 1'b1);
      chk("t5_both_lit", pc_out, 32'h80);
      chk("t5_nopop_lit", 32'(ras_count), 32'd1);

      // 6: reset mid-operation with a loaded stack and sticky flags
      step("t6call", 1'b1, 1'b0, 1'b1, 32'h300, 1'b1, 1'b0);
      chk("t6_cnt2_lit", 32'(ras_count), 32'd2);
      step("t6rst", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("t6_cnt0_lit", 32'(ras_count), 32'd0);
      chk("t6_flags_lit", {30'd0, ras_overflow, ras_underflow}, 32'd0);
      step("t6ret", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      chk("t6_ret_pc_lit", pc_out, 32'h4);

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         logic r, st, rv, cl, rt;
         logic [31:0] tgt;
         r  = ($urandom_range(0, 99) >= 2);
         st = ($urandom_range(0, 99) < 15);
         rv = ($urandom_range(0, 99) < 30);
         cl = ($urandom_range(0, 99) < 55);
         rt = ($urandom_range(0, 99) < 30);
         tgt = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 19) == 0) tgt = 32'hFFFF_FFF8;
         step("rnd", r, st, rv, tgt, cl, rt);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
